// File: rtl/ysyx_040729_clint_pkg.sv
// Shared CLINT definitions: register offsets, bus FSM encoding and the byte-lane
// merge helper used by the memory-mapped peripherals.
package ysyx_040729_clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  // Lanes with a clear strobe keep old_v; lanes with a set strobe take new_v.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_040729_clint_prescaler.sv
// Divides the clock by TICK_DIV (1..65535) and emits a one-cycle tick on the
// last count of each period.
module ysyx_040729_clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // NOTE: combinational blocks assign every output first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (tick_o) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ysyx_040729_clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp on a valid/ready bus, registered
// timer interrupt. Define CLINT_MSIP_EN to add the msip register and msip_o port.
module ysyx_040729_clint
  import ysyx_040729_clint_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
`ifdef CLINT_MSIP_EN
  output logic                    msip_o,
`endif
  output logic                    tirp_o
);

  bus_state_e            state_q;
  logic                  rsp_valid_q, rsp_err_q, tirp_q, tirp_d, tick;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rd_data, mtime_q, mtime_d, mtime_inc;
  logic [DATA_WIDTH-1:0] mtimecmp_q, mtimecmp_d;
  logic                  accept, wr_en, hit_cmp, hit_time, hit_msip, mapped;
  logic                  msip_q, msip_d;

  ysyx_040729_clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .tick_o (tick)
  );

  always_comb begin
    accept    = req_valid && (state_q == IDLE);
    wr_en     = accept && req_write;
    hit_cmp   = (req_addr == ADDR_WIDTH'(CLINT_MTIMECMP_OFF));
    hit_time  = (req_addr == ADDR_WIDTH'(CLINT_MTIME_OFF));
`ifdef CLINT_MSIP_EN
    hit_msip  = (req_addr == ADDR_WIDTH'(CLINT_MSIP_OFF));
`else
    hit_msip  = 1'b0;
`endif
    mapped    = hit_cmp || hit_time || hit_msip;

    // A software write overrides only its lanes; the rest carry this cycle's tick.
    mtime_inc = mtime_q + DATA_WIDTH'(tick);
    mtime_d   = mtime_inc;
    if (wr_en && hit_time) mtime_d = byte_merge(mtime_inc, req_wdata, req_wstrb);

    mtimecmp_d = mtimecmp_q;
    if (wr_en && hit_cmp) mtimecmp_d = byte_merge(mtimecmp_q, req_wdata, req_wstrb);

    msip_d = msip_q;
    if (wr_en && hit_msip && req_wstrb[0]) msip_d = req_wdata[0];

    tirp_d = (mtime_d >= mtimecmp_d);

    // Reads return the pre-tick value; writes and unmapped offsets return zero.
    rd_data = '0;
    if (!req_write) begin
      if (hit_time)      rd_data = mtime_q;
      else if (hit_cmp)  rd_data = mtimecmp_q;
      else if (hit_msip) rd_data = DATA_WIDTH'(msip_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      tirp_q     <= 1'b0;
      msip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      tirp_q     <= tirp_d;
      msip_q     <= msip_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rd_data;
          rsp_err_q   <= !mapped;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign tirp_o    = tirp_q;
`ifdef CLINT_MSIP_EN
  assign msip_o    = msip_q;
`endif

endmodule

// File: tb/tb_ysyx_040729_clint.sv
// Scoreboard bench for the CLINT: one instance with TICK_DIV = 1, one with TICK_DIV = 4.
module tb_ysyx_040729_clint;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1, sel = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;

  logic        rr1, rv1, re1, t1, rr4, rv4, re4, t4;
  logic [63:0] rd1, rd4;
`ifdef CLINT_MSIP_EN
  logic        ms1, ms4;
`endif

  wire         req_ready = sel ? rr4 : rr1;
  wire         rsp_valid = sel ? rv4 : rv1;
  wire         rsp_err   = sel ? re4 : re1;
  wire         tirp      = sel ? t4  : t1;
  wire  [63:0] rsp_rdata = sel ? rd4 : rd1;

  always #5 clock = ~clock;

  ysyx_040729_clint #(.TICK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1),
`ifdef CLINT_MSIP_EN
    .msip_o(ms1),
`endif
    .tirp_o(t1));

  ysyx_040729_clint #(.TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset), .req_valid(req_valid & sel), .req_ready(rr4),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_rdata(rd4), .rsp_err(re4),
`ifdef CLINT_MSIP_EN
    .msip_o(ms4),
`endif
    .tirp_o(t4));

  // Edge counter and a TICK_DIV = 4 phase tracker for the second instance.
  longint cyc = 0;
  int     pre = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) pre <= 0;
    else       pre <= (pre == 3) ? 0 : pre + 1;
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int     checks = 0, errors = 0;
  longint last_acc;
  exp_t   e;
  logic [63:0] gr;
  logic        ge, gt;

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic send(input logic w, input logic [15:0] a, input logic [63:0] d,
                      input logic [7:0] s, input logic [63:0] er, input logic ee,
                      output logic [63:0] rdata, output logic err, output logic t_acc);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    sb.push_back('{er, ee});
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 16'($urandom);
    req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
    @(negedge clock);
    last_acc = cyc;
    t_acc = tirp;
    n = 0;
    while (!rsp_valid && n < 5) begin
      @(negedge clock);
      n++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout addr=%h got rsp_valid=0 want 1", a);
    end
    rdata = rsp_rdata;
    err = rsp_err;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, tirp, rsp_rdata} !== {4'b1000, 64'h0}) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d got rdy=%b vld=%b err=%b tirp=%b rdata=%h want 1 0 0 0 0",
                 i, req_ready, rsp_valid, rsp_err, tirp, rsp_rdata);
      end
    end
    sel = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    send(1'b0, 16'hBFF8, '0, '0, 64'd11, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if (gr < 64'd10 || gr > 64'd12 || ge !== e.err) begin
      errors++;
      $display("FAIL reset_mtime got %0d err=%b want 10..12 err=0", gr, ge);
    end
    send(1'b0, 16'h4000, '0, '0, '1, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL reset_mtimecmp got %h/%b want %h/%b", gr, ge, e.rdata, e.err);
    end
    checks++;
    if (tirp !== 1'b0) begin
      errors++;
      $display("FAIL reset_tirp got %b want 0", tirp);
    end
  endtask

  task automatic test_tirp();
    longint a;
    logic   want;
    sel = 1'b0;
    send(1'b1, 16'h4000, 64'd20, 8'hFF, 64'h0, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL write_cmp_rsp got %h/%b want %h/%b", gr, ge, e.rdata, e.err);
    end
    send(1'b1, 16'hBFF8, 64'd5, 8'hFF, 64'h0, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    a = last_acc;
    checks++;
    if ({gr, ge, gt} !== {e.rdata, e.err, 1'b0}) begin
      errors++;
      $display("FAIL write_mtime5 got %h/%b tirp=%b want %h/%b tirp=0", gr, ge, gt, e.rdata, e.err);
    end
    for (int i = 0; i < 20; i++) begin
      want = ((64'd5 + 64'(cyc - a)) >= 64'd20);
      checks++;
      if (tirp !== want) begin
        errors++;
        $display("FAIL tirp_rise mtime=%0d got %b want %b", 64'd5 + 64'(cyc - a), tirp, want);
      end
      @(negedge clock);
    end
    send(1'b1, 16'h4000, 64'd1000, 8'hFF, 64'h0, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge, gt} !== {e.rdata, e.err, 1'b0}) begin
      errors++;
      $display("FAIL tirp_fall got %h/%b tirp=%b want %h/%b tirp=0", gr, ge, gt, e.rdata, e.err);
    end
  endtask

  task automatic test_wrap();
    longint a;
    sel = 1'b0;
    send(1'b1, 16'h4000, '1, 8'hFF, 64'h0, 1'b0, gr, ge, gt);
    void'(sb.pop_front());
    send(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'h0, 1'b0, gr, ge, gt);
    void'(sb.pop_front());
    a = last_acc;
    checks++;
    if ({gt, tirp} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_tirp_at_max got fe=%b ff=%b want 0 1", gt, tirp);
    end
    @(negedge clock);
    checks++;
    if (tirp !== 1'b0) begin
      errors++;
      $display("FAIL wrap_tirp_after got %b want 0", tirp);
    end
    send(1'b0, 16'hBFF8, '0, '0, 64'hFFFF_FFFF_FFFF_FFFE + 64'(cyc - a), 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err} || e.rdata !== 64'h0) begin
      errors++;
      $display("FAIL wrap_mtime got %h/%b want 0/0", gr, ge);
    end
  endtask

  task automatic test_strobe();
    longint a;
    logic [63:0] base;
    sel = 1'b0;
    send(1'b1, 16'h4000, 64'h1111_1111_2222_2222, 8'h0F, 64'h0, 1'b0, gr, ge, gt);
    void'(sb.pop_front());
    send(1'b0, 16'h4000, '0, '0, 64'hFFFF_FFFF_2222_2222, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL strobe_cmp got %h/%b want %h/%b", gr, ge, e.rdata, e.err);
    end
    // Upper-lane write on a ticking mtime: the low byte must carry the increment.
    send(1'b1, 16'hBFF8, 64'h100, 8'hFF, 64'h0, 1'b0, gr, ge, gt);
    void'(sb.pop_front());
    a = last_acc;
    base = (64'h100 + 64'(cyc - a) + 64'd1) & 64'hFF;
    send(1'b1, 16'hBFF8, 64'h0, 8'hFE, 64'h0, 1'b0, gr, ge, gt);
    void'(sb.pop_front());
    a = last_acc;
    send(1'b0, 16'hBFF8, '0, '0, base + 64'(cyc - a), 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL strobe_mtime_tick got %h want %h", gr, e.rdata);
    end
  endtask

  task automatic test_unmapped();
    sel = 1'b0;
    send(1'b1, 16'h1234, '1, 8'hFF, 64'h0, 1'b1, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL unmapped_write got %h/%b want %h/%b", gr, ge, e.rdata, e.err);
    end
    send(1'b0, 16'h4004, '0, '0, 64'h0, 1'b1, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL unmapped_4004 got %h/%b want %h/%b", gr, ge, e.rdata, e.err);
    end
`ifdef CLINT_MSIP_EN
    send(1'b1, 16'h0000, 64'h1, 8'h01, 64'h0, 1'b0, gr, ge, gt);
    void'(sb.pop_front());
    send(1'b0, 16'h0000, '0, '0, 64'h1, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge, ms1} !== {e.rdata, e.err, 1'b1}) begin
      errors++;
      $display("FAIL msip got %h/%b msip_o=%b want %h/%b msip_o=1", gr, ge, ms1, e.rdata, e.err);
    end
`else
    send(1'b0, 16'h0000, '0, '0, 64'h0, 1'b1, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL msip_unmapped got %h/%b want %h/%b", gr, ge, e.rdata, e.err);
    end
`endif
    send(1'b0, 16'h4000, '0, '0, 64'hFFFF_FFFF_2222_2222, 1'b0, gr, ge, gt);
    e = sb.pop_front();
    checks++;
    if ({gr, ge} !== {e.rdata, e.err}) begin
      errors++;
      $display("FAIL unmapped_no_side_effect got %h want %h", gr, e.rdata);
    end
  endtask

  task automatic test_hold();
    sel = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
    sb.push_back('{64'h0, 1'b1});
    @(posedge clock);
    #1 req_valid = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {2'b10, e.err, e.rdata}) begin
        errors++;
        $display("FAIL hold_%0d got vld=%b rdy=%b err=%b rdata=%h want 1 0 %b %h",
                 i, rsp_valid, req_ready, rsp_err, rsp_rdata, e.err, e.rdata);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_tick_div();
    longint a;
    int     n;
    int     gaps[4] = '{0, 1, 3, 5};
    sel = 1'b1;
    @(negedge clock);
    n = 0;
    while (pre != 3 && n < 8) begin
      @(negedge clock);
      n++;
    end
    send(1'b1, 16'hBFF8, 64'd7, 8'hFF, 64'h0, 1'b0, gr, ge, gt);
    void'(sb.pop_front());
    a = last_acc;
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) @(negedge clock);
      send(1'b0, 16'hBFF8, '0, '0, 64'd7 + 64'((cyc - a) / 4), 1'b0, gr, ge, gt);
      e = sb.pop_front();
      checks++;
      if ({gr, ge} !== {e.rdata, e.err}) begin
        errors++;
        $display("FAIL tickdiv_read_%0d got %0d/%b want %0d/%b", i, gr, ge, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBFF8;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got vld=%b want 1", rsp_valid);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_tirp();
    test_wrap();
    test_strobe();
    test_unmapped();
    test_hold();
    test_tick_div();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
